// File: rtl/aes_block_mode_ctrl.sv
// ECB/CBC/CTR chaining controller around a single aes_top core, with an
// IV/counter register, a valid/ready command port and an in-order output FIFO.
module aes_block_mode_ctrl #(
  parameter int BLK_S     = 128,
  parameter int KEY_S     = 128,
  parameter int CTR_W     = 32,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [1:0]       s_cmd,
  input  logic [1:0]       s_mode,
  input  logic [KEY_S-1:0] s_key,
  input  logic [BLK_S-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [BLK_S-1:0] m_data,
  output logic             err,
  output logic             key_valid,
  output logic             core_en,
  output logic [KEY_S-1:0] core_key,
  output logic [BLK_S-1:0] core_in_blk,
  output logic             core_cipher_mode,
  output logic             core_decipher_mode,
  output logic             core_key_exp_mode,
  input  logic [BLK_S-1:0] core_out_blk,
  input  logic             core_en_o
);

  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(OUT_DEPTH);

  localparam logic [1:0] CMD_KEY = 2'd0;
  localparam logic [1:0] CMD_IV  = 2'd1;
  localparam logic [1:0] CMD_ENC = 2'd2;
  localparam logic [1:0] CMD_DEC = 2'd3;
  localparam logic [1:0] MODE_CBC = 2'd1;
  localparam logic [1:0] MODE_CTR = 2'd2;
  localparam logic [1:0] MODE_BAD = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state, state_nxt;
  logic [1:0]       cmd_r, mode_r;
  logic [BLK_S-1:0] data_r;
  logic [KEY_S-1:0] key_r;
  logic [BLK_S-1:0] iv, iv_nxt;
  logic             err_r, kv_r;
  logic [BLK_S-1:0] fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_count;
  logic             accept, reject, done, has_out, push, pop, is_crypt;
  logic [BLK_S-1:0] result;

  // Increment only the low CTR_W bits of the IV; upper bits pass through.
  function automatic logic [BLK_S-1:0] ctr_inc(input logic [BLK_S-1:0] v);
    logic [BLK_S-1:0] mask;
    logic [BLK_S-1:0] sum;
    for (int i = 0; i < BLK_S; i++) mask[i] = (i < CTR_W);
    sum = v + BLK_S'(1);
    return (v & ~mask) | (sum & mask);
  endfunction

  assign s_ready  = (state == IDLE) && !reset && (fifo_count < DEPTH_C);
  assign accept   = s_valid && s_ready;
  assign reject   = ((s_cmd == CMD_ENC) || (s_cmd == CMD_DEC)) && (!kv_r || (s_mode == MODE_BAD));
  assign done     = (state == WAIT) && core_en_o;
  assign is_crypt = (cmd_r == CMD_ENC) || (cmd_r == CMD_DEC);
  assign push     = done && has_out;
  assign pop      = m_valid && m_ready;

  assign m_valid   = (fifo_count != '0);
  assign m_data    = m_valid ? fifo_mem[rd_ptr] : '0;
  assign err       = err_r;
  assign key_valid = kv_r;
  assign core_key  = key_r;

  always_comb begin
    core_in_blk = data_r;
    if (is_crypt && (mode_r == MODE_CTR)) core_in_blk = iv;
    else if ((cmd_r == CMD_ENC) && (mode_r == MODE_CBC)) core_in_blk = data_r ^ iv;
  end

  always_comb begin
    result  = core_out_blk;
    iv_nxt  = iv;
    has_out = is_crypt;
    if (is_crypt) begin
      case (mode_r)
        MODE_CBC: begin
          if (cmd_r == CMD_ENC) begin
            iv_nxt = core_out_blk;
          end else begin
            result = core_out_blk ^ iv;
            iv_nxt = data_r;
          end
        end
        MODE_CTR: begin
          result = core_out_blk ^ data_r;
          iv_nxt = ctr_inc(iv);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt          = state;
    core_en            = 1'b0;
    core_key_exp_mode  = 1'b0;
    core_cipher_mode   = 1'b0;
    core_decipher_mode = 1'b0;
    case (state)
      IDLE:  if (accept && (s_cmd != CMD_IV) && !reject) state_nxt = ISSUE;
      ISSUE: begin
        core_en            = 1'b1;
        core_key_exp_mode  = (cmd_r == CMD_KEY);
        core_cipher_mode   = (cmd_r == CMD_ENC) || ((cmd_r == CMD_DEC) && (mode_r == MODE_CTR));
        core_decipher_mode = (cmd_r == CMD_DEC) && (mode_r != MODE_CTR);
        state_nxt          = WAIT;
      end
      WAIT:    if (core_en_o) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: reset returns everything to idle and drops any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      iv         <= '0;
      kv_r       <= 1'b0;
      err_r      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state <= state_nxt;
      err_r <= accept && reject;
      if (accept && (s_cmd == CMD_IV)) iv <= s_data;
      else if (done)                   iv <= iv_nxt;
      if (done && (cmd_r == CMD_KEY)) kv_r <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_count <= fifo_count + (PTR_W+1)'(1);
      else if (pop && !push) fifo_count <= fifo_count - (PTR_W+1)'(1);
    end
  end

  // Datapath registers carry no reset; they are only read once qualified by control.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_r  <= s_cmd;
      mode_r <= s_mode;
      data_r <= s_data;
    end
    if (accept && (s_cmd == CMD_KEY)) key_r <= s_key;
    if (push) fifo_mem[wr_ptr] <= result;
  end

endmodule

// File: tb/tb_aes_block_mode_ctrl.sv
// Scoreboard bench for aes_block_mode_ctrl with a behavioural core stub and a
// chaining reference model kept in plain procedural code.
module tb_aes_block_mode_ctrl;

  localparam int DEPTH = 2;
  localparam logic [127:0] K0 = 128'h754620676e754b20796d207374616854;
  localparam logic [127:0] P0 = 128'h6F775420656E694E20656E4F206F7754;
  localparam logic [127:0] C0 = 128'h3ad7021ab3992240f62014575f50c329;
  localparam logic [1:0] KEY_EXP = 2'd0, SET_IV = 2'd1, ENC = 2'd2, DEC = 2'd3;
  localparam logic [1:0] ECB = 2'd0, CBC = 2'd1, CTR = 2'd2, BAD = 2'd3;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid, s_ready, m_valid, m_ready, err, key_valid;
  logic [1:0]   s_cmd, s_mode;
  logic [127:0] s_key, s_data, m_data, core_key, core_in_blk, core_out_blk;
  logic         core_en, core_cipher_mode, core_decipher_mode, core_key_exp_mode, core_en_o;

  aes_block_mode_ctrl #(.BLK_S(128), .KEY_S(128), .CTR_W(32), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_cmd(s_cmd), .s_mode(s_mode),
    .s_key(s_key), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err(err), .key_valid(key_valid),
    .core_en(core_en), .core_key(core_key), .core_in_blk(core_in_blk),
    .core_cipher_mode(core_cipher_mode), .core_decipher_mode(core_decipher_mode),
    .core_key_exp_mode(core_key_exp_mode),
    .core_out_blk(core_out_blk), .core_en_o(core_en_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = -1;
  int en_seen = 0;
  int en_exp = 0;
  bit err_exp = 0;
  bit rnd_rdy = 0;
  logic [127:0] exp_q[$];
  logic [127:0] sb_e;

  // reference model state
  bit           m_kv;
  logic [127:0] m_key, m_iv;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in block cipher: the published test vector plus an invertible rotate/xor.
  function automatic logic [127:0] aes_e(input logic [127:0] k, input logic [127:0] x);
    if (k == K0 && x == P0) return C0;
    return {x[114:0], x[127:115]} ^ k;
  endfunction

  function automatic logic [127:0] aes_d(input logic [127:0] k, input logic [127:0] y);
    logic [127:0] z;
    if (k == K0 && y == C0) return P0;
    z = y ^ k;
    return {z[12:0], z[127:13]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Core stub: captures the request while core_en is high, answers after 1..4 cycles.
  initial begin
    logic [127:0] stub_key;
    logic [127:0] r;
    stub_key     = '0;
    core_en_o    = 1'b0;
    core_out_blk = '0;
    forever begin
      @(posedge clk); #1;
      if (core_en) begin
        if (core_key_exp_mode) begin
          stub_key = core_key;
          r = '0;
        end else if (core_cipher_mode) begin
          r = aes_e(stub_key, core_in_blk);
        end else begin
          r = aes_d(stub_key, core_in_blk);
        end
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        core_en_o    = 1'b1;
        core_out_blk = r;
        @(posedge clk); #1;
        core_en_o    = 1'b0;
        core_out_blk = '0;
      end
    end
  end

  // Monitors: output scoreboard, err pulse, core_en pulse and mode one-hot.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h expected no output", m_data);
        end else begin
          sb_e = exp_q.pop_front();
          if (m_data !== sb_e) begin
            errors++;
            $display("FAIL sb_data: got %h expected %h", m_data, sb_e);
          end
        end
      end
      checks++;
      if (err !== err_exp) begin
        errors++;
        $display("FAIL err_pulse: got %b expected %b at cycle %0d", err, err_exp, cyc);
      end
      err_exp = 0;
      if (core_en) begin
        en_seen++;
        checks++;
        if (cyc != acc_cyc || $countones({core_key_exp_mode, core_cipher_mode, core_decipher_mode}) != 1) begin
          errors++;
          $display("FAIL core_en_timing: got cycle %0d modes %b%b%b expected cycle %0d one-hot",
                   cyc, core_key_exp_mode, core_cipher_mode, core_decipher_mode, acc_cyc);
        end
      end else if (core_key_exp_mode || core_cipher_mode || core_decipher_mode) begin
        checks++;
        errors++;
        $display("FAIL mode_idle: got modes %b%b%b expected 000",
                 core_key_exp_mode, core_cipher_mode, core_decipher_mode);
      end
    end
  end

  task automatic send_cmd(input logic [1:0] cmd, input logic [1:0] mode,
                          input logic [127:0] key, input logic [127:0] data);
    int n;
    bit rej;
    logic [127:0] e;
    s_valid = 1'b1; s_cmd = cmd; s_mode = mode; s_key = key; s_data = data;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready || n >= 300) break;
      @(posedge clk); #1;
      n++;
      if (rnd_rdy) m_ready = ($urandom_range(0, 3) != 0);
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: cmd %0d not accepted after %0d cycles", cmd, n);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    acc_cyc = cyc;
    rej = (cmd == ENC || cmd == DEC) && (!m_kv || mode == BAD);
    err_exp = rej;
    if (!rej) begin
      case (cmd)
        KEY_EXP: begin m_key = key; m_kv = 1; en_exp++; end
        SET_IV:  m_iv = data;
        default: begin
          en_exp++;
          if (mode == ECB) begin
            e = (cmd == ENC) ? aes_e(m_key, data) : aes_d(m_key, data);
          end else if (mode == CBC) begin
            if (cmd == ENC) begin
              e = aes_e(m_key, data ^ m_iv);
              m_iv = e;
            end else begin
              e = aes_d(m_key, data) ^ m_iv;
              m_iv = data;
            end
          end else begin
            e = aes_e(m_key, m_iv) ^ data;
            m_iv[31:0] = m_iv[31:0] + 32'd1;
          end
          exp_q.push_back(e);
        end
      endcase
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (s_ready) break;
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: s_ready still %b after %0d cycles", s_ready, n);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int c1, n, r;
    logic [1:0] cmd, mode;
    reset = 1'b1; s_valid = 1'b0; s_cmd = 2'd0; s_mode = 2'd0;
    s_key = '0; s_data = '0; m_ready = 1'b1;
    m_kv = 0; m_key = '0; m_iv = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 128'(s_ready), 128'd0);
    chk("rst_m_valid", 128'(m_valid), 128'd0);
    chk("rst_m_data", m_data, 128'd0);
    chk("rst_key_valid", 128'(key_valid), 128'd0);
    chk("rst_core_en", 128'(core_en), 128'd0);
    chk("rst_iv", dut.iv, 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", 128'(s_ready), 128'd1);
    @(posedge clk); #1;

    send_cmd(ENC, ECB, '0, P0);
    @(negedge clk);
    chk("nokey_s_ready", 128'(s_ready), 128'd1);
    chk("nokey_m_valid", 128'(m_valid), 128'd0);
    @(posedge clk); #1;

    send_cmd(KEY_EXP, ECB, K0, '0);
    send_cmd(ENC, ECB, '0, P0);
    send_cmd(DEC, ECB, '0, C0);
    send_cmd(SET_IV, ECB, '0, '0);
    send_cmd(ENC, CBC, '0, P0);
    wait_idle();
    chk("cbc_enc_iv", dut.iv, C0);
    send_cmd(SET_IV, ECB, '0, '0);
    send_cmd(DEC, CBC, '0, C0);
    wait_idle();
    chk("cbc_dec_iv", dut.iv, C0);
    send_cmd(SET_IV, ECB, '0, P0);
    send_cmd(ENC, CTR, '0, '0);
    wait_idle();
    chk("ctr_iv_inc", dut.iv, 128'h6F775420656E694E20656E4F206F7755);
    send_cmd(SET_IV, ECB, '0, {96'h0123456789abcdef01234567, 32'hffffffff});
    send_cmd(DEC, CTR, '0, rnd128());
    wait_idle();
    chk("ctr_iv_wrap", dut.iv, {96'h0123456789abcdef01234567, 32'h0});

    send_cmd(SET_IV, ECB, '0, rnd128());
    c1 = acc_cyc;
    send_cmd(SET_IV, ECB, '0, rnd128());
    chk("set_iv_b2b", 128'(acc_cyc), 128'(c1 + 1));
    chk("set_iv_value", dut.iv, m_iv);

    send_cmd(ENC, BAD, '0, P0);
    @(negedge clk);
    chk("badmode_s_ready", 128'(s_ready), 128'd1);
    @(posedge clk); #1;

    // FIFO backpressure with a 2-deep output queue
    m_ready = 1'b0;
    send_cmd(ENC, ECB, '0, rnd128());
    send_cmd(ENC, ECB, '0, rnd128());
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("full_s_ready", 128'(s_ready), 128'd0);
    chk("full_m_valid", 128'(m_valid), 128'd1);
    chk("full_count", 128'(dut.fifo_count), 128'd2);
    @(posedge clk); #1;
    fork
      send_cmd(ENC, ECB, '0, rnd128());
      begin
        repeat (3) begin
          @(negedge clk);
          chk("full_blocks", 128'(s_ready), 128'd0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    // push and pop on the same edge
    m_ready = 1'b0;
    send_cmd(ENC, CBC, '0, rnd128());
    wait_idle();
    send_cmd(ENC, ECB, '0, rnd128());
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!core_en_o && n < 20);
    chk("done_seen", 128'(core_en_o), 128'd1);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    chk("pushpop_count", 128'(dut.fifo_count), 128'd1);
    chk("pushpop_m_valid", 128'(m_valid), 128'd1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    // reset while waiting on the core
    send_cmd(ENC, ECB, '0, rnd128());
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    m_kv = 0;
    m_iv = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("wrst_m_valid", 128'(m_valid), 128'd0);
    chk("wrst_key_valid", 128'(key_valid), 128'd0);
    chk("wrst_iv", dut.iv, 128'd0);
    chk("wrst_s_ready", 128'(s_ready), 128'd1);
    repeat (8) @(negedge clk);
    chk("late_done_m_valid", 128'(m_valid), 128'd0);
    @(posedge clk); #1;

    // randomized traffic with random output backpressure
    send_cmd(KEY_EXP, ECB, rnd128(), '0);
    rnd_rdy = 1;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      cmd = (r == 0) ? KEY_EXP : (r <= 2) ? SET_IV : (r <= 6) ? ENC : DEC;
      r = $urandom_range(0, 9);
      mode = (r == 0) ? BAD : 2'(r % 3);
      m_ready = ($urandom_range(0, 3) != 0);
      send_cmd(cmd, mode, rnd128(), rnd128());
    end
    rnd_rdy = 0;
    m_ready = 1'b1;
    wait_idle();
    repeat (10) @(posedge clk);
    chk("rand_iv", dut.iv, m_iv);
    chk("sb_drained", 128'(exp_q.size()), 128'd0);
    chk("core_en_count", 128'(en_seen), 128'(en_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_block_mode_ctrl.md
# aes_block_mode_ctrl

Parametrised block-mode controller that wraps one `aes_top` core and adds ECB, CBC and CTR chaining, which the bare core does not provide. It also adds an IV/counter register, a valid/ready command interface and a registered output FIFO. It sits between the upstream command/data source and the downstream consumer, and drives the core's `en`/`en_o` pulse interface. One command is in flight at a time.

## Interface
- `BLK_S`, 128: block width; fixed by the core.
- `KEY_S`, 128: key width; fixed by the core.
- `CTR_W`, 32: width of the low IV field incremented in CTR mode; 1..`BLK_S`.
- `OUT_DEPTH`, 4: output FIFO depth in blocks; a power of 2, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; also drives the core's `reset`.
- `s_valid`  in  1  command valid.
- `s_ready`  out  1  command accepted when `s_valid && s_ready` at a rising edge.
- `s_cmd`  in  2  0=KEY_EXP, 1=SET_IV, 2=ENCRYPT, 3=DECRYPT.
- `s_mode`  in  2  0=ECB, 1=CBC, 2=CTR, 3=illegal. Sampled for ENCRYPT/DECRYPT only.
- `s_key`  in  `KEY_S`  key; sampled for KEY_EXP only.
- `s_data`  in  `BLK_S`  IV (SET_IV) or input block (ENCRYPT/DECRYPT).
- `m_valid`  out  1  FIFO head valid.
- `m_ready`  in  1  pop when `m_valid && m_ready`.
- `m_data`  out  `BLK_S`  FIFO head block.
- `err`  out  1  one-cycle pulse on a rejected command.
- `key_valid`  out  1  set after a completed KEY_EXP.
- `core_en`  out  1  one-cycle start pulse to the core.
- `core_key`  out  `KEY_S`  key to the core.
- `core_in_blk`  out  `BLK_S`  block to the core.
- `core_cipher_mode`  out  1  core mode select.
- `core_decipher_mode`  out  1  core mode select.
- `core_key_exp_mode`  out  1  core mode select.
- `core_out_blk`  in  `BLK_S`  core result; valid while `core_en_o` is high.
- `core_en_o`  in  1  core one-cycle done pulse.

## Operation
FSM states: IDLE, ISSUE, WAIT.
- IDLE: `s_ready = (fifo_count < OUT_DEPTH)`. At acceptance, `s_cmd`, `s_mode` and `s_data` are registered.
- Transitions out of IDLE:
  - SET_IV: `iv <= s_data`; stays in IDLE; no core op, no output.
  - Rejected command: ENCRYPT/DECRYPT with `key_valid=0` or `s_mode=3`. `err` pulses the next cycle; stays in IDLE; no core op, no output.
  - Otherwise: go to ISSUE.
- ISSUE: drive `core_en=1` and the mode bits for one cycle, then go to WAIT. `s_ready=0`.
- WAIT: `s_ready=0`. On `core_en_o`: compute the result, push it to the FIFO if the command produces one, update `iv`, return to IDLE.

Per-command datapath (P = plaintext input, C = ciphertext input, K = `core_out_blk`):
- KEY_EXP: `core_key_exp_mode=1`, `core_key=s_key`. On done, `key_valid<=1`. No output.
- ENC ECB: core in P, cipher. Output K.
- ENC CBC: core in P^iv, cipher. Output K; `iv<=K`.
- ENC CTR and DEC CTR: core in iv, cipher mode. Output K^data. `iv[CTR_W-1:0] += 1` modulo 2^CTR_W; upper bits unchanged.
- DEC ECB: core in C, decipher. Output K.
- DEC CBC: core in C, decipher. Output K^iv; then `iv<=C`.

Other rules:
- `core_key_exp_mode`, `core_cipher_mode` and `core_decipher_mode` are one-hot while `core_en=1`; all three are 0 otherwise.
- `core_key` holds the last KEY_EXP key.
- FIFO: registered, in-order.
  - Push and pop in the same cycle leave the count unchanged.
  - Push only ever occurs with count < `OUT_DEPTH`, guaranteed by `s_ready` gating.
  - Pop while empty is ignored.
- `core_en_o` outside WAIT is ignored.
- Reset values: `s_ready=0` during reset, then 1; `m_valid=0`, `m_data=0`, `err=0`, `key_valid=0`, `core_en=0`, all mode bits 0, `iv=0`, FIFO empty, FSM in IDLE.
- Reset mid-operation, any state: the next cycle has the reset values, and any in-flight result is discarded.

## Timing
- Acceptance at edge T0 → `core_en` high in cycle T0..T1 only.
- Core done at edge Td (`core_en_o` sampled high) → `m_valid` high from Td; `s_ready` high again from Td if the FIFO has room.
- `err` is high for exactly the cycle after acceptance of a rejected command; `s_ready` stays high.
- SET_IV takes one cycle; a back-to-back command in the next cycle is accepted.
- `m_data`/`m_valid` hold while `m_valid && !m_ready`.

## Test plan
- KEY_EXP with `s_key=754620676e754b20796d207374616854`, then ENC ECB with `s_data=6F775420656E694E20656E4F206F7754` → `m_data=3ad7021ab3992240f62014575f50c329`. `core_en` is high for exactly one cycle per command.
- DEC ECB of `3ad7021ab3992240f62014575f50c329` → `6F775420656E694E20656E4F206F7754`. Then SET_IV 0, ENC CBC of the same plaintext → `3ad7...c329` and `iv=3ad7...c329`. Then DEC CBC after SET_IV 0 → the original plaintext.
- SET_IV `6F775420656E694E20656E4F206F7754`, ENC CTR with data 0 → `3ad7021ab3992240f62014575f50c329` and `iv=6F775420656E694E20656E4F206F7755`. With `CTR_W=32` and IV low word `FFFFFFFF` → low word wraps to 0 and upper bits are unchanged.
- Fresh reset, ENC ECB → `err` pulses once, no `m_valid`, `s_ready` back next cycle. `s_mode=3` after KEY_EXP → same response.
- `OUT_DEPTH=2`, `m_ready=0`, three ECB encrypts issued:
  - After two results, `s_ready=0`.
  - Raise `m_ready` → results drain in order, then the third command is accepted.
  - Simultaneous push and pop keeps the count.
- Assert `reset` while in WAIT → next cycle `m_valid=0`, `key_valid=0`, `iv=0`. A late `core_en_o` produces no output.
